// File: rtl/cpu_pkg.sv
// Shared CPU definitions: boot-sequencer states, halt encoding
// and default core/memory dimensions.
package cpu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 64;

  localparam logic [31:0] HALT_ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE_LAST,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// 32-bit run-cycle counter with clear, enable and a terminal-count
// flag that freezes the count at MAX_CYCLES-1.
module run_cycle_counter #(
  parameter int MAX_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        tc
);

  localparam logic [31:0] LAST = 32'(MAX_CYCLES - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/cpu_boot_sequencer.sv
// Run-control sequencer: loads a program into instruction memory,
// releases the core, and stops it on ecall or cycle budget.
module cpu_boot_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] HALT_INST = WIDTH'(HALT_ECALL),
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              run_req,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              cpu_start,
  input  logic [WIDTH-1:0]  cpu_inst,
  input  logic [WIDTH-1:0]  cpu_pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic              len_err,
  output logic [WIDTH-1:0]  halt_pc,
  output logic [31:0]       cycle_count
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_t          state;
  state_t          nxt;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] len;
  logic            accept;
  logic            len_ok;
  logic            load_go;
  logic            run_go;
  logic            hs;
  logic            is_halt;
  logic            tc;
  logic            cnt_clr;
  logic            cnt_en;

  always_comb begin
    accept  = (state == S_IDLE) || (state == S_HALTED)
           || (state == S_TIMEOUT);
    len_ok  = (load_len != '0) && (load_len <= LEN_MAX);
    load_go = accept && load_req && len_ok;
    run_go  = accept && !load_req && run_req;
    s_ready = (state == S_LOAD);
    hs      = s_ready && s_valid && !abort;
    is_halt = (cpu_inst == HALT_INST);
    cnt_clr = load_go || run_go || (state == S_WRITE_LAST);
    cnt_en  = (state == S_RUN);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (load_go)     nxt = S_LOAD;
        else if (run_go) nxt = S_RUN;
      end
      S_LOAD: begin
        if (abort) nxt = S_IDLE;
        else if (hs && ptr == len - 1'b1) nxt = S_WRITE_LAST;
      end
      S_WRITE_LAST: nxt = S_RUN;
      S_RUN: begin
        if (abort)        nxt = S_IDLE;
        else if (is_halt) nxt = S_HALTED;
        else if (tc)      nxt = S_TIMEOUT;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      len        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      len_err    <= 1'b0;
      halt_pc    <= '0;
    end else begin
      state     <= nxt;
      cpu_start <= (nxt == S_RUN);
      busy      <= (nxt == S_LOAD) || (nxt == S_WRITE_LAST)
                || (nxt == S_RUN);
      halted    <= (nxt == S_HALTED);
      timeout   <= (nxt == S_TIMEOUT);
      imem_we   <= hs;
      if (accept && load_req) begin
        len_err <= !len_ok;
      end
      if (load_go) begin
        len <= load_len;
        ptr <= '0;
      end
      if (load_go || run_go) begin
        halt_pc <= '0;
      end
      if (hs) begin
        imem_addr  <= ptr[ADDR_W-1:0];
        imem_wdata <= s_data;
        ptr        <= ptr + 1'b1;
      end
      // abort outranks a halt seen in the same cycle
      if (state == S_RUN && !abort && is_halt) begin
        halt_pc <= cpu_pc;
      end
    end
  end

  run_cycle_counter #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cycle_count),
    .tc   (tc)
  );

endmodule
